stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. Selects a source either from an explicit select input (select mode) or by round-robin arbitration (RR mode). Keeps a packet on one channel until its last beat. It sits between multiple producer streams and a single consumer, and generalises the team's combinational 4:1 mux with registering, back-pressure and packet locking.

---
 rtl/stream_mux_rr.sv | 199 +++++++++++++++++++
 tb/tb_stream_mux_rr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-channel, W-bit registered stream multiplexer with valid/ready handshakes.
// A source is chosen either by an explicit select input (mode=0) or by
// round-robin arbitration (mode=1). Once a multi-beat packet starts, the
// channel stays granted until its last beat is accepted.
//
// Handshake rule (all interfaces): a beat transfers in a cycle where valid
// and ready are both 1. valid must not depend on ready. in_ready is
// combinational from the arbiter state and the current inputs. The output
// side is a single register that can drain and reload in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = select mode, 1 = round-robin mode (sampled only in IDLE)
//   sel        channel choice in select mode (sampled only in IDLE)
//   in_data    channel i on bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready, at most one bit set
//   out_data   registered output beat
//   out_valid  registered output valid
//   out_last   registered end-of-packet flag
//   out_chan   source channel of the current output beat
//   out_ready  consumer ready
//   dbg_state  arbiter state (0 = IDLE, 1 = LOCKED)
//   dbg_ptr    round-robin pointer
//
// SEL_W must equal $clog2(CHANNELS).

module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic                      dbg_state,
  output logic [SEL_W-1:0]          dbg_ptr
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] locked_chan, locked_chan_n;
  // Remembers whether the locked packet was started in round-robin mode, so
  // that the pointer update at its end does not depend on a mid-packet mode
  // change.
  logic             locked_rr, locked_rr_n;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             have_grant;
  logic             active_rr;
  logic             load_en;
  logic             accept;
  logic             grant_last;
  logic [WIDTH-1:0] grant_data;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  assign dbg_state = (state == LOCKED);
  assign dbg_ptr   = ptr;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan starting at ptr. Iterating from the far end down to
  // offset 0 lets the closest valid channel overwrite any farther one.
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (in_valid[idx]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(idx);
      end
    end
  end

  // Grant selection.
  always_comb begin
    grant      = '0;
    have_grant = 1'b0;
    active_rr  = mode;
    unique case (state)
      IDLE: begin
        if (mode) begin
          grant      = rr_idx;
          have_grant = rr_found;
        end else begin
          // Select mode offers ready regardless of the chosen channel's valid.
          grant      = sel;
          have_grant = (int'(sel) < CHANNELS);
        end
      end
      LOCKED: begin
        grant      = locked_chan;
        have_grant = 1'b1;
        active_rr  = locked_rr;
      end
      default: begin
        grant      = '0;
        have_grant = 1'b0;
      end
    endcase
    if (rst) begin
      have_grant = 1'b0;
    end
  end

  assign load_en    = !out_valid || out_ready;
  assign grant_last = in_last[grant];
  assign grant_data = chan_data[grant];
  assign accept     = have_grant && load_en && in_valid[grant];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (have_grant && (int'(grant) == i)) begin
        in_ready[i] = load_en;
      end
    end
  end

  // Next-state logic for the arbiter.
  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    locked_chan_n = locked_chan;
    locked_rr_n   = locked_rr;
    if (accept) begin
      if (grant_last) begin
        state_n = IDLE;
        if (active_rr) begin
          ptr_n = SEL_W'((int'(grant) + 1) % CHANNELS);
        end
      end else begin
        state_n       = LOCKED;
        locked_chan_n = grant;
        locked_rr_n   = active_rr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      locked_chan <= '0;
      locked_rr   <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      locked_chan <= locked_chan_n;
      locked_rr   <= locked_rr_n;
    end
  end

  // Output register: an accepted beat always wins, which covers the
  // drain-and-reload case without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_last  <= grant_last;
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (WIDTH=8, CHANNELS=4).
module tb_stream_mux_rr;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_last;
  logic [SW-1:0] out_chan;
  logic          out_ready;
  logic          dbg_state;
  logic [SW-1:0] dbg_ptr;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  logic [SW-1:0] exp_q[$];

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  // At most one in_ready bit may be high in any cycle.
  always @(negedge clk) begin
    if (!done) check("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
  end

  initial begin
    logic [SW-1:0] e;
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0;
    in_data = '0; out_ready = 1'b0;
    tick();
    in_valid = 4'b1111;
    settle();
    check("rst_ready", 32'(in_ready), 32'h0);
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_chan",  32'(out_chan),  32'd0);
    check("rst_ptr",   32'(dbg_ptr),   32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Select mode
    rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_last = 4'b1111;
    set_data(8'h11, 8'h22, 8'hA5, 8'h44); out_ready = 1'b1;
    settle();
    check("sel_ready", 32'(in_ready), 32'h4);
    tick();
    check("sel_data",  32'(out_data),  32'hA5);
    check("sel_chan",  32'(out_chan),  32'd2);
    check("sel_last",  32'(out_last),  32'd1);
    check("sel_valid", 32'(out_valid), 32'd1);
    check("sel_ptr",   32'(dbg_ptr),   32'd0);
    in_valid = 4'b0000;
    settle();
    check("sel_ready_novalid", 32'(in_ready), 32'h4);
    tick();
    check("sel_drain", 32'(out_valid), 32'd0);

    // Round-robin fairness
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    set_data(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    for (int i = 0; i < 8; i++) begin
      e = SW'(i % N);
      settle();
      check("rr_ready", 32'(in_ready), 32'(1) << e);
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      check("rr_chan",  32'(out_chan),  32'(e));
      check("rr_data",  32'(out_data),  32'h0A0 + 32'h11 * 32'(e));
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_ptr",   32'(dbg_ptr),   32'((int'(e) + 1) % N));
    end
    in_valid = '0;
    tick();
    check("rr_drain", 32'(out_valid), 32'd0);

    // Packet lock: single beat on ch0 moves ptr to 1, then ch1 sends 3 beats
    in_valid = 4'b0001; in_last = 4'b0001;
    tick();
    check("lk_pre_chan", 32'(out_chan), 32'd0);
    check("lk_pre_ptr",  32'(dbg_ptr),  32'd1);
    in_valid = 4'b0111; in_last = 4'b0000;
    set_data(8'h50, 8'h51, 8'h60, 8'h70);
    settle();
    check("lk_b1_ready", 32'(in_ready), 32'h2);
    tick();
    check("lk_b1_chan",  32'(out_chan),  32'd1);
    check("lk_b1_data",  32'(out_data),  32'h51);
    check("lk_b1_last",  32'(out_last),  32'd0);
    check("lk_b1_state", 32'(dbg_state), 32'd1);
    mode = 1'b0; sel = 2'd0; set_data(8'h50, 8'h52, 8'h60, 8'h70);
    settle();
    check("lk_b2_ready", 32'(in_ready), 32'h2);
    tick();
    check("lk_b2_chan", 32'(out_chan), 32'd1);
    check("lk_b2_data", 32'(out_data), 32'h52);
    mode = 1'b1; sel = 2'd3; in_last = 4'b0010; set_data(8'h50, 8'h53, 8'h60, 8'h70);
    settle();
    check("lk_b3_ready", 32'(in_ready), 32'h2);
    tick();
    check("lk_b3_chan",  32'(out_chan),  32'd1);
    check("lk_b3_data",  32'(out_data),  32'h53);
    check("lk_b3_last",  32'(out_last),  32'd1);
    check("lk_b3_state", 32'(dbg_state), 32'd0);
    check("lk_b3_ptr",   32'(dbg_ptr),   32'd2);
    in_last = 4'b0111;
    settle();
    check("lk_next_ready", 32'(in_ready), 32'h4);
    tick();
    check("lk_next_chan", 32'(out_chan), 32'd2);
    check("lk_next_data", 32'(out_data), 32'h60);
    check("lk_next_ptr",  32'(dbg_ptr),  32'd3);
    in_valid = '0;
    tick();

    // Back-pressure
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_last = 4'b0010;
    set_data(8'h00, 8'h3C, 8'h00, 8'h00); out_ready = 1'b0;
    settle();
    check("bp_ready0", 32'(in_ready), 32'h2);
    tick();
    check("bp_load", 32'(out_data), 32'h3C);
    set_data(8'h00, 8'h77, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_ready_hold", 32'(in_ready), 32'h0);
      tick();
      check("bp_data_hold",  32'(out_data),  32'h3C);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    settle();
    check("bp_ready_rel", 32'(in_ready), 32'h2);
    tick();
    check("bp_reload_data",  32'(out_data),  32'h77);
    check("bp_reload_valid", 32'(out_valid), 32'd1);
    in_valid = '0;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);
    check("bp_ptr",   32'(dbg_ptr),   32'd3);

    // Reset mid-packet on ch3
    mode = 1'b1; in_valid = 4'b1000; in_last = 4'b0000;
    set_data(8'h00, 8'h00, 8'h00, 8'h91);
    settle();
    check("mr_ready", 32'(in_ready), 32'h8);
    tick();
    check("mr_b1_chan",  32'(out_chan),  32'd3);
    check("mr_b1_state", 32'(dbg_state), 32'd1);
    rst = 1'b1; set_data(8'h00, 8'h00, 8'h00, 8'h92);
    settle();
    check("mr_rst_ready", 32'(in_ready), 32'h0);
    tick();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_chan",  32'(out_chan),  32'd0);
    check("mr_data",  32'(out_data),  32'h0);
    check("mr_ptr",   32'(dbg_ptr),   32'd0);
    check("mr_state", 32'(dbg_state), 32'd0);
    rst = 1'b0; in_valid = 4'b1111; in_last = 4'b1111;
    settle();
    check("mr_after_ready", 32'(in_ready), 32'h1);
    tick();
    check("mr_after_chan", 32'(out_chan), 32'd0);
    in_valid = '0;
    tick();

    // Sparse requests with ptr=0 and wrap-around
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; in_valid = '0;
    settle();
    check("sp_none_ready", 32'(in_ready), 32'h0);
    tick();
    check("sp_none_ptr",   32'(dbg_ptr),   32'd0);
    check("sp_none_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b1000; in_last = 4'b0000; set_data(8'h00, 8'h00, 8'h00, 8'hE1);
    settle();
    check("sp_b1_ready", 32'(in_ready), 32'h8);
    tick();
    check("sp_b1_chan", 32'(out_chan), 32'd3);
    in_last = 4'b1000; set_data(8'h00, 8'h00, 8'h00, 8'hE2);
    settle();
    check("sp_b2_ready", 32'(in_ready), 32'h8);
    tick();
    check("sp_b2_chan",  32'(out_chan),  32'd3);
    check("sp_b2_data",  32'(out_data),  32'hE2);
    check("sp_b2_last",  32'(out_last),  32'd1);
    check("sp_b2_ptr",   32'(dbg_ptr),   32'd0);
    check("sp_b2_state", 32'(dbg_state), 32'd0);
    in_valid = '0;
    tick();

    // Final report
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
